kofn_voter_seq: RTL and testbench
=================================

// Module: kofn_voter_seq
// PURPOSE
//  Registered, parametrised k-of-N threshold voter: generalises the fixed 3-of-5 combinational voter.
//  Samples N redundant channel bits, counts ones and votes against a run-time threshold.
//  A persistence filter changes the output only after HOLD consecutive disagreeing votes.
//  Sits between redundant sensor/logic channels and downstream control as a glitch-tolerant decision stage.
// PARAMETERS
//  N      5  number of input channels (>=1)
//  K_DEF  3  threshold after reset (1..N)
//  HOLD   2  consecutive disagreeing valid votes needed to flip vote_out (>=1)
//  CNT_W  8  width of saturating statistics counters
//  FLT_LIM 16  disagreement count at which a channel is flagged faulty (VOTER_DISAGREE_EN only)
// PORTS
//  clk         in   1           clock, rising edge
//  rst_n       in   1           asynchronous active-low reset
//  in_valid    in   1           in_vec is sampled this cycle
//  in_vec      in   N           channel bits
//  thresh_load in   1           load thresh into the threshold register
//  thresh      in   TW          new threshold, TW = $clog2(N+1)
//  clr_stats   in   1           synchronous clear of toggle_cnt and disagreement counters
//  ones_cnt    out  TW          popcount of the last valid sample
//  vote_raw    out  1           unfiltered vote (ones_cnt >= thresh_q) of the last valid sample
//  vote_valid  out  1           one-cycle strobe: ones_cnt/vote_raw updated
//  vote_out    out  1           filtered vote
//  toggle_cnt  out  CNT_W       saturating count of vote_out transitions
//  fault_mask  out  N           per-channel fault flags (0 when feature compiled out)
// BEHAVIOUR
//  Reset (async, rst_n=0): ones_cnt=0, vote_raw=0, vote_valid=0, vote_out=0, toggle_cnt=0,
//   fault_mask=0, thresh_q=K_DEF, run count=0, FSM=INIT. Reset mid-run discards all state immediately.
//  Stage 1 (edge after in_valid=1): ones_cnt, vote_raw registered; vote_valid=1 for one cycle.
//   in_valid=0 -> stage-1 outputs hold, vote_valid=0.
//  Threshold: thresh_load samples thresh at the edge; 0 clamps to 1, >N clamps to N.
//   thresh_load with in_valid in the same cycle: that sample uses the OLD thresh_q.
//  Stage 2 filter FSM, advances only on cycles where vote_valid=1:
//   INIT:    first valid vote -> vote_out=vote_raw with no hold; toggle_cnt not incremented; -> STABLE.
//   STABLE:  vote_raw==vote_out -> stay; differs -> run=1; if HOLD==1 flip now, else -> PENDING.
//   PENDING: vote_raw==vote_out -> run=0, -> STABLE; differs -> run++; run==HOLD -> flip, run=0, -> STABLE.
//   Flip: vote_out inverts, toggle_cnt += 1, saturating at 2^CNT_W-1.
//  Latency: in_valid sample to vote_raw = 1 cycle; to vote_out (HOLD=1) = 2 cycles.
//  Cycles with vote_valid=0 neither advance nor break a run.
//  clr_stats coincident with a flip: clear wins, toggle_cnt=0.
// CONFIGURATION
//  VOTER_DISAGREE_EN defined: per-channel CNT_W saturating counter, incremented on every vote_valid cycle
//   where the channel's sampled bit != vote_raw.
//   fault_mask[i] = (cnt[i] >= FLT_LIM); cleared with the counters by clr_stats (clear wins over increment).
//  VOTER_DISAGREE_EN undefined: no counters synthesised; fault_mask tied to 0.
// STRUCTURE
//  voter_pkg: FSM state enum {INIT, STABLE, PENDING}; function thresh_w(N) = $clog2(N+1);
//   function popcount(). Shared by this block and its testbench.
//  Sub-module vote_filter: the stage-2 FSM, run counter and toggle_cnt.
//   Ports: clk, rst_n, vote_valid, vote_raw, clr_stats, vote_out, toggle_cnt.
//  Top holds stage 1, the threshold register and the optional disagreement counters.
// TESTING
//  Defaults; samples 11100, 00011, 11111 -> ones_cnt 3,2,5; vote_raw 1,0,1; first vote_out=1 with no hold.
//  HOLD=2, vote_out=1; raw 0,1,0,0 -> vote_out stays 1 until the 4th vote, then 0; toggle_cnt=1.
//  Load thresh=0 -> acts as 1; load thresh=7 (N=5) -> acts as 5; 11110 then votes 0.
//   Load with in_valid in the same cycle -> that sample uses the old threshold.
//  Valid gaps: raw 0, idle 3 cycles, raw 0 (HOLD=2) -> flip on the 2nd vote.
//   Assert rst_n low mid-PENDING -> all outputs 0; the next vote is handled as INIT.
//  VOTER_DISAGREE_EN, FLT_LIM=16: channel 0 stuck 0 against 16 votes of 1 -> fault_mask=00001 after the 16th.
//   clr_stats -> mask 0.
//  Saturation: CNT_W=2, force 5 flips -> toggle_cnt=3; clr_stats on a flip cycle -> toggle_cnt=0.

Source files
------------

// File: rtl/kofn_voter_seq_pkg.sv
// Shared types and helpers for the k-of-N sequential voter and its bench.
package kofn_voter_seq_pkg;

   typedef enum logic [1:0] {
      ST_INIT    = 2'd0,
      ST_STABLE  = 2'd1,
      ST_PENDING = 2'd2
   } filt_state_t;

   localparam int POP_MAX_W = 64;

   function automatic int thresh_w(input int n);
      return $clog2(n + 1);
   endfunction

   // Channel vectors are zero-extended to POP_MAX_W bits before counting.
   function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
      int unsigned c;
      c = 0;
      for (int i = 0; i < POP_MAX_W; i++) begin
         if (v[i]) c++;
      end
      return c;
   endfunction

endpackage

// File: rtl/kofn_voter_seq_if.sv
// Channel/threshold/statistics bundle between the voter and its driver.
interface kofn_voter_seq_if #(
   parameter int N     = 5,
   parameter int CNT_W = 8
);
   localparam int TW = kofn_voter_seq_pkg::thresh_w(N);

   logic             in_valid;
   logic [N-1:0]     in_vec;
   logic             thresh_load;
   logic [TW-1:0]    thresh;
   logic             clr_stats;
   logic [TW-1:0]    ones_cnt;
   logic             vote_raw;
   logic             vote_valid;
   logic             vote_out;
   logic [CNT_W-1:0] toggle_cnt;
   logic [N-1:0]     fault_mask;

   modport master (
      output in_valid, in_vec, thresh_load, thresh, clr_stats,
      input  ones_cnt, vote_raw, vote_valid, vote_out, toggle_cnt, fault_mask
   );

   modport slave (
      input  in_valid, in_vec, thresh_load, thresh, clr_stats,
      output ones_cnt, vote_raw, vote_valid, vote_out, toggle_cnt, fault_mask
   );
endinterface

// File: rtl/kofn_voter_seq_vote_filter.sv
// Persistence filter: vote_out follows vote_raw only after HOLD consecutive disagreeing votes.
//   state      | meaning
//   ST_INIT    | no vote seen since reset; first vote is adopted directly
//   ST_STABLE  | vote_out agrees with the last vote, run = 0
//   ST_PENDING | run (1..HOLD-1) consecutive votes have disagreed with vote_out
module vote_filter
   import kofn_voter_seq_pkg::*;
#(
   parameter int HOLD  = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             vote_valid,
   input  logic             vote_raw,
   input  logic             clr_stats,
   output logic             vote_out,
   output logic [CNT_W-1:0] toggle_cnt
);
   localparam int RW = $clog2(HOLD + 1);

   filt_state_t   state;
   logic [RW-1:0] run;
   logic          differ;
   logic          flip;

   always_comb begin
      differ = (vote_raw != vote_out);
      flip   = 1'b0;
      if (vote_valid && differ) begin
         case (state)
            ST_STABLE:  flip = (HOLD == 1);
            ST_PENDING: flip = ((int'(run) + 1) == HOLD);
            default:    flip = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_INIT;
         run        <= '0;
         vote_out   <= 1'b0;
         toggle_cnt <= '0;
      end else begin
         // A clear in the same cycle as a flip must leave the counter at zero.
         if (clr_stats)
            toggle_cnt <= '0;
         else if (flip && (toggle_cnt != '1))
            toggle_cnt <= toggle_cnt + 1'b1;

         if (vote_valid) begin
            case (state)
               ST_INIT: begin
                  vote_out <= vote_raw;
                  run      <= '0;
                  state    <= ST_STABLE;
               end
               ST_STABLE: begin
                  if (differ) begin
                     if (flip) begin
                        vote_out <= ~vote_out;
                        run      <= '0;
                     end else begin
                        run   <= RW'(1);
                        state <= ST_PENDING;
                     end
                  end
               end
               ST_PENDING: begin
                  if (!differ) begin
                     run   <= '0;
                     state <= ST_STABLE;
                  end else if (flip) begin
                     vote_out <= ~vote_out;
                     run      <= '0;
                     state    <= ST_STABLE;
                  end else begin
                     run <= run + 1'b1;
                  end
               end
               default: begin
                  run   <= '0;
                  state <= ST_INIT;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/kofn_voter_seq.sv
// Registered k-of-N threshold voter with persistence filter.
// Define VOTER_DISAGREE_EN to build per-channel disagreement counters and fault_mask.
module kofn_voter_seq
   import kofn_voter_seq_pkg::*;
#(
   parameter int N       = 5,
   parameter int K_DEF   = 3,
   parameter int HOLD    = 2,
   parameter int CNT_W   = 8,
   parameter int FLT_LIM = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   kofn_voter_seq_if.slave bus
);
   localparam int TW = thresh_w(N);

   logic [TW-1:0]    thresh_q;
   logic [TW-1:0]    ones_q;
   logic             raw_q;
   logic             valid_q;
   logic [TW-1:0]    ones_c;
   logic             vote_out_w;
   logic [CNT_W-1:0] toggle_w;
   logic [N-1:0]     fault_mask_c;

   always_comb begin
      logic [POP_MAX_W-1:0] vec_ext;
      vec_ext          = '0;
      vec_ext[N-1:0]   = bus.in_vec;
      ones_c           = TW'(popcount(vec_ext));
   end

   // Out-of-range loads clamp to 1..N so the threshold is always meaningful.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         thresh_q <= TW'(K_DEF);
      else if (bus.thresh_load) begin
         if (bus.thresh == '0)
            thresh_q <= TW'(1);
         else if (int'(bus.thresh) > N)
            thresh_q <= TW'(N);
         else
            thresh_q <= bus.thresh;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ones_q  <= '0;
         raw_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            ones_q <= ones_c;
            raw_q  <= (ones_c >= thresh_q);
         end
      end
   end

   vote_filter #(
      .HOLD  (HOLD),
      .CNT_W (CNT_W)
   ) u_filter (
      .clk        (clk),
      .rst_n      (rst_n),
      .vote_valid (valid_q),
      .vote_raw   (raw_q),
      .clr_stats  (bus.clr_stats),
      .vote_out   (vote_out_w),
      .toggle_cnt (toggle_w)
   );

`ifdef VOTER_DISAGREE_EN
   logic [N-1:0]     vec_q;
   logic [CNT_W-1:0] dis_cnt [N];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         vec_q <= '0;
      else if (bus.in_valid)
         vec_q <= bus.in_vec;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) dis_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (bus.clr_stats)
               dis_cnt[i] <= '0;
            else if (valid_q && (vec_q[i] != raw_q) && (dis_cnt[i] != '1))
               dis_cnt[i] <= dis_cnt[i] + 1'b1;
         end
      end
   end

   always_comb begin
      fault_mask_c = '0;
      for (int i = 0; i < N; i++)
         fault_mask_c[i] = (int'(dis_cnt[i]) >= FLT_LIM);
   end
`else
   assign fault_mask_c = '0;
`endif

   assign bus.ones_cnt   = ones_q;
   assign bus.vote_raw   = raw_q;
   assign bus.vote_valid = valid_q;
   assign bus.vote_out   = vote_out_w;
   assign bus.toggle_cnt = toggle_w;
   assign bus.fault_mask = fault_mask_c;

endmodule

// File: tb/tb_kofn_voter_seq.sv
// Directed bench for kofn_voter_seq: default instance plus a HOLD=1, CNT_W=2 instance.
module tb_kofn_voter_seq;
   import kofn_voter_seq_pkg::*;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_err;

   kofn_voter_seq_if #(.N(5), .CNT_W(8)) if0 ();
   kofn_voter_seq_if #(.N(5), .CNT_W(2)) if1 ();

   kofn_voter_seq #(.N(5), .K_DEF(3), .HOLD(2), .CNT_W(8), .FLT_LIM(16)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if0.slave)
   );

   kofn_voter_seq #(.N(5), .K_DEF(3), .HOLD(1), .CNT_W(2), .FLT_LIM(16)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] vec;
      int         ones;
      logic       raw;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic v, input logic [4:0] vec, input logic ld = 1'b0,
                      input logic [2:0] th = 3'd0, input logic clr = 1'b0);
      if0.in_valid = v;  if0.in_vec = vec;  if0.thresh_load = ld;
      if0.thresh   = th; if0.clr_stats = clr;
      if1.in_valid = v;  if1.in_vec = vec;  if1.thresh_load = ld;
      if1.thresh   = th; if1.clr_stats = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      if0.in_valid = 1'b0; if0.in_vec = '0; if0.thresh_load = 1'b0;
      if0.thresh   = '0;   if0.clr_stats = 1'b0;
      if1.in_valid = 1'b0; if1.in_vec = '0; if1.thresh_load = 1'b0;
      if1.thresh   = '0;   if1.clr_stats = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      tbl[0] = '{vec: 5'b11100, ones: 3, raw: 1'b1};
      tbl[1] = '{vec: 5'b00011, ones: 2, raw: 1'b0};
      tbl[2] = '{vec: 5'b11111, ones: 5, raw: 1'b1};
      tbl[3] = '{vec: 5'b00000, ones: 0, raw: 1'b0};
      tbl[4] = '{vec: 5'b10101, ones: 3, raw: 1'b1};
      tbl[5] = '{vec: 5'b00001, ones: 1, raw: 1'b0};

      rst_n = 1'b0;
      if0.in_valid = 1'b0; if0.in_vec = '0; if0.thresh_load = 1'b0;
      if0.thresh   = '0;   if0.clr_stats = 1'b0;
      if1.in_valid = 1'b0; if1.in_vec = '0; if1.thresh_load = 1'b0;
      if1.thresh   = '0;   if1.clr_stats = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ones",   int'(if0.ones_cnt),   0);
      chk("rst_raw",    int'(if0.vote_raw),   0);
      chk("rst_vvalid", int'(if0.vote_valid), 0);
      chk("rst_vout",   int'(if0.vote_out),   0);
      chk("rst_toggle", int'(if0.toggle_cnt), 0);
      chk("rst_mask",   int'(if0.fault_mask), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // First vote is adopted without hold; then the stage-1 table back to back.
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, tbl[i].vec);
         chk($sformatf("tbl%0d_ones", i), int'(if0.ones_cnt), tbl[i].ones);
         chk($sformatf("tbl%0d_raw", i),  int'(if0.vote_raw), int'(tbl[i].raw));
         chk($sformatf("tbl%0d_vv", i),   int'(if0.vote_valid), 1);
         if (i == 1) chk("first_vout_nohold", int'(if0.vote_out), 1);
      end
      cyc(1'b0, 5'b00000);
      chk("idle_vv",     int'(if0.vote_valid), 0);
      chk("idle_ones",   int'(if0.ones_cnt), 1);
      chk("alt_vout",    int'(if0.vote_out), 1);
      chk("alt_toggle",  int'(if0.toggle_cnt), 0);

      // HOLD=2: raw 0,1,0,0 after an initial 1.
      do_reset();
      cyc(1'b1, 5'b11111);
      cyc(1'b1, 5'b00000);
      cyc(1'b1, 5'b11111);
      cyc(1'b1, 5'b00000);
      cyc(1'b1, 5'b00000);
      chk("hold_before", int'(if0.vote_out), 1);
      cyc(1'b0, 5'b00000);
      chk("hold_flip",   int'(if0.vote_out), 0);
      chk("hold_toggle", int'(if0.toggle_cnt), 1);
      cyc(1'b0, 5'b00000, 1'b0, 3'd0, 1'b1);
      chk("clr_toggle",  int'(if0.toggle_cnt), 0);

      // Threshold clamping and same-cycle load.
      do_reset();
      cyc(1'b0, 5'b00000, 1'b1, 3'd0);
      cyc(1'b1, 5'b00001);
      chk("th0_ones", int'(if0.ones_cnt), 1);
      chk("th0_raw",  int'(if0.vote_raw), 1);
      cyc(1'b0, 5'b00000, 1'b1, 3'd7);
      cyc(1'b1, 5'b11110);
      chk("th7_raw4", int'(if0.vote_raw), 0);
      cyc(1'b1, 5'b11111);
      chk("th7_raw5", int'(if0.vote_raw), 1);
      cyc(1'b1, 5'b00110, 1'b1, 3'd2);
      chk("ld_same_old", int'(if0.vote_raw), 0);
      cyc(1'b1, 5'b00110);
      chk("ld_next_new", int'(if0.vote_raw), 1);

      // Idle gaps neither advance nor break a pending run.
      do_reset();
      cyc(1'b1, 5'b11111);
      cyc(1'b1, 5'b00000);
      repeat (3) cyc(1'b0, 5'b00000);
      chk("gap_hold", int'(if0.vote_out), 1);
      cyc(1'b1, 5'b00000);
      cyc(1'b0, 5'b00000);
      chk("gap_flip",   int'(if0.vote_out), 0);
      chk("gap_toggle", int'(if0.toggle_cnt), 1);

      // Async reset while PENDING, then the next vote is handled as INIT.
      do_reset();
      cyc(1'b1, 5'b11111);
      cyc(1'b1, 5'b00000);
      cyc(1'b0, 5'b00000);
      chk("pend_vout", int'(if0.vote_out), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_vout", int'(if0.vote_out), 0);
      chk("arst_ones", int'(if0.ones_cnt), 0);
      chk("arst_raw",  int'(if0.vote_raw), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc(1'b1, 5'b11111);
      cyc(1'b0, 5'b00000);
      chk("post_rst_init",   int'(if0.vote_out), 1);
      chk("post_rst_toggle", int'(if0.toggle_cnt), 0);

      // HOLD=1, CNT_W=2 instance: 5 flips saturate at 3; clear beats a flip.
      do_reset();
      cyc(1'b1, 5'b11111);
      cyc(1'b1, 5'b00000);
      cyc(1'b1, 5'b11111);
      cyc(1'b1, 5'b00000);
      chk("sat_mid", int'(if1.toggle_cnt), 2);
      cyc(1'b1, 5'b11111);
      cyc(1'b1, 5'b00000);
      cyc(1'b0, 5'b00000);
      chk("sat_cnt",  int'(if1.toggle_cnt), 3);
      chk("sat_vout", int'(if1.vote_out), 0);
      cyc(1'b1, 5'b11111);
      cyc(1'b0, 5'b00000, 1'b0, 3'd0, 1'b1);
      chk("clr_flip_cnt",  int'(if1.toggle_cnt), 0);
      chk("clr_flip_vout", int'(if1.vote_out), 1);

      // Channel 0 stuck at 0 against 16 votes of 1.
      do_reset();
      for (int i = 0; i < 16; i++) cyc(1'b1, 5'b11110);
`ifdef VOTER_DISAGREE_EN
      chk("flt_before", int'(if0.fault_mask), 0);
      cyc(1'b0, 5'b00000);
      chk("flt_after",  int'(if0.fault_mask), 1);
      cyc(1'b0, 5'b00000, 1'b0, 3'd0, 1'b1);
      chk("flt_clr",    int'(if0.fault_mask), 0);
`else
      cyc(1'b0, 5'b00000);
      chk("flt_off", int'(if0.fault_mask), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
